// File: rtl/jk_cmd_sequencer_if.sv
// Command channel for the JK sequencer: valid/ready handshake carrying op and repeat count.
interface jk_cmd_sequencer_if #(
   parameter int unsigned CNT_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_rep;

   modport master (output cmd_valid, output cmd_op, output cmd_rep, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_rep, output cmd_ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Drives one-cycle J/K pulses per accepted command, checks the flop's Q against
// an internal model after a settle window, and tracks mismatches.
module jk_cmd_sequencer #(
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned ERR_W  = 8
) (
   input  logic              Ck,
   input  logic              reset_,
   jk_cmd_sequencer_if.slave cmd,
   output logic              J,
   output logic              K,
   input  logic              Q,
   output logic              busy,
   output logic              done,
   output logic              mismatch,
   output logic [ERR_W-1:0]  err_count
);

   localparam int unsigned WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_WAIT  = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [1:0]         op, op_nxt;
   logic [CNT_W-1:0]   rem, rem_nxt;
   logic [WAIT_W-1:0]  wcnt, wcnt_nxt;
   logic               model, model_nxt;
   logic               j_nxt, k_nxt, busy_nxt, done_nxt, mismatch_nxt;
   logic [ERR_W-1:0]   err_nxt;

   // Ready depends only on state so a held-high valid cannot loop back into it.
   assign cmd.cmd_ready = (state == S_IDLE);

   // State and registered outputs; synchronous reset returns everything to idle.
   always_ff @(posedge Ck) begin
      if (reset_) begin
         state     <= S_IDLE;
         op        <= 2'd0;
         rem       <= '0;
         wcnt      <= '0;
         model     <= 1'b0;
         J         <= 1'b0;
         K         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mismatch  <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         op        <= op_nxt;
         rem       <= rem_nxt;
         wcnt      <= wcnt_nxt;
         model     <= model_nxt;
         J         <= j_nxt;
         K         <= k_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         mismatch  <= mismatch_nxt;
         err_count <= err_nxt;
      end
   end

   // Next-state logic; J/K are loaded on entry to DRIVE so they are high only there.
   always_comb begin
      state_nxt    = state;
      op_nxt       = op;
      rem_nxt      = rem;
      wcnt_nxt     = wcnt;
      model_nxt    = model;
      j_nxt        = 1'b0;
      k_nxt        = 1'b0;
      done_nxt     = 1'b0;
      mismatch_nxt = mismatch;
      err_nxt      = err_count;

      case (state)
         S_IDLE: begin
            if (cmd.cmd_valid) begin
               op_nxt    = cmd.cmd_op;
               rem_nxt   = cmd.cmd_rep;
               j_nxt     = cmd.cmd_op[0];
               k_nxt     = cmd.cmd_op[1];
               state_nxt = S_DRIVE;
            end
         end
         S_DRIVE: begin
            case (op)
               2'd1:    model_nxt = 1'b1;
               2'd2:    model_nxt = 1'b0;
               2'd3:    model_nxt = ~model;
               default: model_nxt = model;
            endcase
            wcnt_nxt  = WAIT_W'(SETTLE - 1);
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (wcnt == '0) begin
               state_nxt = S_CHECK;
            end else begin
               wcnt_nxt = wcnt - 1'b1;
            end
         end
         S_CHECK: begin
            if (Q != model) begin
               mismatch_nxt = 1'b1;
               if (err_count != '1) begin
                  err_nxt = err_count + 1'b1;
               end
            end
            if (rem != '0) begin
               rem_nxt   = rem - 1'b1;
               j_nxt     = op[0];
               k_nxt     = op[1];
               state_nxt = S_DRIVE;
            end else begin
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench: behavioural JK flop plus a per-command reference model.
module tb_jk_cmd_sequencer;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned SETTLE = 1;
   localparam int unsigned ERR_W  = 8;
   localparam int unsigned APP    = SETTLE + 2;

   logic             Ck = 1'b0;
   logic             reset_ = 1'b1;
   logic             J, K, Q, busy, done, mismatch;
   logic [ERR_W-1:0] err_count;
   logic             flop = 1'b0;
   bit               stuck = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int jcnt = 0, kcnt = 0, jk_viol = 0;
   bit prev_jk = 1'b0;

   logic m = 1'b0;       // expected flop / model value
   int   tot_err = 0;    // unsaturated failed-check total

   jk_cmd_sequencer_if #(.CNT_W(CNT_W)) cmd_bus ();

   jk_cmd_sequencer #(.CNT_W(CNT_W), .SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
      .Ck(Ck), .reset_(reset_), .cmd(cmd_bus), .J(J), .K(K), .Q(Q),
      .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count)
   );

   always #5 Ck = ~Ck;

   // Behavioural JK flop, cleared by the same reset.
   always @(posedge Ck) begin
      if (reset_) flop <= 1'b0;
      else case ({J, K})
         2'b10:   flop <= 1'b1;
         2'b01:   flop <= 1'b0;
         2'b11:   flop <= ~flop;
         default: flop <= flop;
      endcase
   end
   assign Q = stuck ? 1'b0 : flop;

   // Pulse counters and adjacency watch.
   always @(negedge Ck) begin
      if ((J | K) && prev_jk) jk_viol++;
      prev_jk = J | K;
      jcnt += int'(J);
      kcnt += int'(K);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic apply_op(input logic [1:0] op, input logic q);
      case (op)
         2'd1:    return 1'b1;
         2'd2:    return 1'b0;
         2'd3:    return ~q;
         default: return q;
      endcase
   endfunction

   function automatic int sat_err(input int t);
      return (t > 255) ? 255 : t;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!cmd_bus.cmd_ready && n < 200) begin
         @(posedge Ck); #1; n++;
      end
      check_eq("ready_timeout", 32'(cmd_bus.cmd_ready), 32'd1);
   endtask

   // Issue one command, follow it to done, check Q at each check cycle and totals.
   task automatic do_cmd(input logic [1:0] op, input logic [CNT_W-1:0] rep, input bit sq);
      logic exp_q [16];
      int   j0, k0, cyc, apps, new_err;
      apps = int'(rep) + 1;
      new_err = 0;
      for (int i = 0; i < apps; i++) begin
         m = apply_op(op, m);
         exp_q[i] = m;
         if (sq && m) new_err++;
      end
      tot_err += new_err;
      wait_ready();
      stuck = sq;
      j0 = jcnt; k0 = kcnt;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_rep   = rep;
      @(posedge Ck); #1;
      cmd_bus.cmd_valid = 1'b0;
      cyc = 0;
      while (cyc < 100) begin
         @(posedge Ck); #1; cyc++;
         if (!sq && (cyc % APP) == APP - 1 && cyc / APP < apps)
            check_eq("q_at_check", 32'(Q), 32'(exp_q[cyc / APP]));
         if (done) break;
      end
      check_eq("latency", 32'(cyc), 32'(apps * APP));
      check_eq("j_pulses", 32'(jcnt - j0), 32'(op[0] ? apps : 0));
      check_eq("k_pulses", 32'(kcnt - k0), 32'(op[1] ? apps : 0));
      check_eq("err_count", 32'(err_count), 32'(sat_err(tot_err)));
      check_eq("mismatch", 32'(mismatch), 32'(tot_err > 0));
      stuck = 1'b0;
   endtask

   initial begin
      int acc, dn, last_acc, bad_gap, jset, kclr, drain;
      logic rdy;
      logic [1:0] last_op;
      logic [1:0] rop;
      logic [CNT_W-1:0] rrep;

      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_op    = 2'd0;
      cmd_bus.cmd_rep   = '0;
      repeat (3) @(posedge Ck);
      #1 reset_ = 1'b0;

      // Reset state
      check_eq("rst_j", 32'(J), 32'd0);
      check_eq("rst_k", 32'(K), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_mismatch", 32'(mismatch), 32'd0);
      check_eq("rst_err", 32'(err_count), 32'd0);
      check_eq("rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);

      // Directed: single SET, TOGGLE x4, full-width repeat
      do_cmd(2'd1, 4'd0, 1'b0);
      do_cmd(2'd2, 4'd0, 1'b0);
      do_cmd(2'd3, 4'd3, 1'b0);
      do_cmd(2'd3, 4'd15, 1'b0);
      do_cmd(2'd0, 4'd2, 1'b0);

      // Q stuck at 0: two failing checks, then a clean CLEAR adds none
      do_cmd(2'd1, 4'd1, 1'b1);
      check_eq("stuck_err2", 32'(err_count), 32'd2);
      do_cmd(2'd2, 4'd0, 1'b0);
      check_eq("clean_keeps_err", 32'(err_count), 32'd2);

      // Valid held high, op alternating SET/CLEAR after each acceptance
      wait_ready();
      acc = 0; dn = 0; last_acc = -1; bad_gap = 0; jset = jcnt; kclr = kcnt;
      last_op = 2'd1;
      cmd_bus.cmd_op = 2'd1; cmd_bus.cmd_rep = '0; cmd_bus.cmd_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         rdy = cmd_bus.cmd_ready;
         @(posedge Ck); #1;
         if (done) dn++;
         if (rdy) begin
            acc++;
            if (last_acc >= 0 && c - last_acc != int'(SETTLE) + 3) bad_gap++;
            last_acc = c;
            last_op = cmd_bus.cmd_op;
            cmd_bus.cmd_op = (cmd_bus.cmd_op == 2'd1) ? 2'd2 : 2'd1;
         end
      end
      cmd_bus.cmd_valid = 1'b0;
      drain = 0;
      while (busy && drain < 50) begin
         @(posedge Ck); #1; drain++;
         if (done) dn++;
      end
      check_eq("bb_accepts", 32'(acc), 32'(40 / (SETTLE + 3)));
      check_eq("bb_gap", 32'(bad_gap), 32'd0);
      check_eq("bb_dones", 32'(dn), 32'(acc));
      check_eq("bb_j", 32'(jcnt - jset), 32'((acc + 1) / 2));
      check_eq("bb_k", 32'(kcnt - kclr), 32'(acc / 2));
      m = (last_op == 2'd1);
      check_eq("bb_q", 32'(Q), 32'(m));
      check_eq("bb_err", 32'(err_count), 32'(sat_err(tot_err)));

      // Randomized commands against the reference model
      for (int i = 0; i < 40; i++) begin
         rop  = 2'($urandom_range(0, 3));
         rrep = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 15))
                                            : CNT_W'($urandom_range(0, 2));
         do_cmd(rop, rrep, ($urandom_range(0, 3) == 0));
      end

      // Reset during WAIT of TOGGLE rep=5
      wait_ready();
      cmd_bus.cmd_op = 2'd3; cmd_bus.cmd_rep = 4'd5; cmd_bus.cmd_valid = 1'b1;
      @(posedge Ck); #1;
      cmd_bus.cmd_valid = 1'b0;
      @(posedge Ck); #1;
      reset_ = 1'b1;
      @(posedge Ck); #1;
      reset_ = 1'b0;
      m = 1'b0; tot_err = 0;
      check_eq("mid_rst_j", 32'(J), 32'd0);
      check_eq("mid_rst_k", 32'(K), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      check_eq("mid_rst_err", 32'(err_count), 32'd0);
      check_eq("mid_rst_mismatch", 32'(mismatch), 32'd0);
      dn = 0;
      repeat (20) begin
         @(posedge Ck); #1;
         if (done) dn++;
      end
      check_eq("mid_rst_no_done", 32'(dn), 32'd0);
      do_cmd(2'd3, 4'd1, 1'b0);

      // Saturation: 17 x 16 failing checks
      for (int i = 0; i < 17; i++) do_cmd(2'd1, 4'd15, 1'b1);
      check_eq("sat_err", 32'(err_count), 32'd255);
      check_eq("sat_mismatch", 32'(mismatch), 32'd1);

      check_eq("jk_adjacent", 32'(jk_viol), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
